// File: rtl/seg_capture.sv
// Seven-segment scan monitor: debounces each multiplexed (pattern, select) pair,
// decodes it back to a digit code per position and strobes each complete frame.
module seg_capture #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_led,
  input  logic [DIGITS-1:0]     seg_sel,
  output logic [4*DIGITS-1:0]   digit_code,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic                  sel_err
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [7:0]          s_seg;
  logic [DIGITS-1:0]   s_sel;
  logic [CNT_W-1:0]    cnt;
  logic                chg;
  logic                multi_q;
  logic [DIGITS-1:0]   mask;

  logic                onehot_c;
  logic                multi_c;
  logic                stable_c;
  logic                pair_diff_c;
  logic                capture_c;
  logic                frame_c;
  logic [DIGITS-1:0]   mask_nxt_c;
  logic [3:0]          dec_code_c;
  logic                dec_err_c;

  assign onehot_c    = $onehot(s_sel);
  assign multi_c     = (s_sel != '0) && !onehot_c;
  assign stable_c    = (cnt == CNT_MAX);
  assign pair_diff_c = (seg_led != s_seg) || (seg_sel != s_sel);

  // Input sampling; cnt counts identical samples including the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg   <= '0;
      s_sel   <= '0;
      cnt     <= '0;
      chg     <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      s_seg   <= seg_led;
      s_sel   <= seg_sel;
      chg     <= pair_diff_c;
      multi_q <= multi_c;
      if (pair_diff_c)
        cnt <= CNT_W'(1);
      else if (!stable_c)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a fresh pair that is already stable (STABLE_CYCLES=1) goes straight to HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (onehot_c) state_nxt = stable_c ? HOLD : SETTLE;
      end
      SETTLE: begin
        if (!onehot_c)     state_nxt = IDLE;
        else if (stable_c) state_nxt = HOLD;
      end
      HOLD: begin
        if (chg) begin
          if (!onehot_c) state_nxt = IDLE;
          else           state_nxt = stable_c ? HOLD : SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output/control decode: capture once per stable pair, never while holding an unchanged pair.
  always_comb begin
    capture_c  = 1'b0;
    mask_nxt_c = mask;
    frame_c    = 1'b0;
    if (onehot_c && stable_c && ((state != HOLD) || chg))
      capture_c = 1'b1;
    if (capture_c) begin
      mask_nxt_c = mask | s_sel;
      frame_c    = &mask_nxt_c;
    end
  end

  // Segment pattern back to digit code; dp or unknown patterns map to E.
  always_comb begin
    dec_err_c  = 1'b0;
    dec_code_c = 4'hE;
    case (s_seg)
      8'h3f: dec_code_c = 4'h0;
      8'h06: dec_code_c = 4'h1;
      8'h5b: dec_code_c = 4'h2;
      8'h4f: dec_code_c = 4'h3;
      8'h66: dec_code_c = 4'h4;
      8'h6d: dec_code_c = 4'h5;
      8'h7d: dec_code_c = 4'h6;
      8'h07: dec_code_c = 4'h7;
      8'h7f: dec_code_c = 4'h8;
      8'h6f: dec_code_c = 4'h9;
      8'h00: dec_code_c = 4'hF;
      default: begin
        dec_code_c = 4'hE;
        dec_err_c  = 1'b1;
      end
    endcase
  end

  // Registered outputs and captured-position mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_code  <= {DIGITS{4'hF}};
      digit_err   <= '0;
      mask        <= '0;
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      frame_valid <= frame_c;
      sel_err     <= multi_c && !multi_q;
      mask        <= frame_c ? '0 : mask_nxt_c;
      if (capture_c) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (s_sel[i]) begin
            digit_code[4*i +: 4] <= dec_code_c;
            digit_err[i]         <= dec_err_c;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: directed scan sequences, expected output
// updates/frames/select faults queued by the driver and checked by a monitor.
module tb_seg_capture;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_led;
  logic [3:0]  seg_sel;
  logic [15:0] digit_code;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        sel_err;

  seg_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_led(seg_led), .seg_sel(seg_sel),
    .digit_code(digit_code), .digit_err(digit_err),
    .frame_valid(frame_valid), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] code; logic [3:0] err; } upd_t;
  typedef struct { int cyc; logic [15:0] code; } frm_t;
  upd_t q_upd[$];
  frm_t q_frm[$];
  int   q_sel[$];

  int checks = 0;
  int errors = 0;

  logic [15:0] m_code = 16'hFFFF;
  logic [3:0]  m_err  = 4'h0;
  logic [3:0]  m_mask = 4'h0;

  logic        armed = 1'b0;
  logic [15:0] prev_code;
  logic [3:0]  prev_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void dec(input logic [7:0] s, output logic [3:0] c, output logic e);
    e = 1'b0;
    case (s)
      8'h3f: c = 4'h0;  8'h06: c = 4'h1;  8'h5b: c = 4'h2;  8'h4f: c = 4'h3;
      8'h66: c = 4'h4;  8'h6d: c = 4'h5;  8'h7d: c = 4'h6;  8'h07: c = 4'h7;
      8'h7f: c = 4'h8;  8'h6f: c = 4'h9;  8'h00: c = 4'hF;
      default: begin c = 4'hE; e = 1'b1; end
    endcase
  endfunction

  // Drive one pair for n cycles and queue what the display should show.
  task automatic step(input logic [3:0] sel, input logic [7:0] seg, input int n);
    int c0;
    logic [3:0] d;
    logic e;
    logic [15:0] nc;
    logic [3:0] ne;
    upd_t u;
    frm_t f;
    seg_sel = sel;
    seg_led = seg;
    c0 = cyc;
    if ($onehot(sel) && n >= int'(STABLE)) begin
      dec(seg, d, e);
      nc = m_code;
      ne = m_err;
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) begin
          nc[4*i +: 4] = d;
          ne[i] = e;
        end
      end
      if (nc != m_code || ne != m_err) begin
        u.code = nc; u.err = ne;
        q_upd.push_back(u);
      end
      m_code = nc;
      m_err  = ne;
      m_mask = m_mask | sel;
      if (&m_mask) begin
        f.cyc = c0 + int'(STABLE) + 1;
        f.code = nc;
        q_frm.push_back(f);
        m_mask = 4'h0;
      end
    end
    if (sel != 4'h0 && !$onehot(sel)) q_sel.push_back(c0 + 2);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_rst(input int n);
    upd_t u;
    rst = 1'b1;
    seg_sel = 4'h0;
    seg_led = 8'h00;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    if (m_code != 16'hFFFF || m_err != 4'h0) begin
      u.code = 16'hFFFF; u.err = 4'h0;
      q_upd.push_back(u);
    end
    m_code = 16'hFFFF;
    m_err  = 4'h0;
    m_mask = 4'h0;
  endtask

  // Monitor: compares every output change, frame strobe and select-fault strobe.
  always @(negedge clk) begin
    if (armed) begin
      if (digit_code !== prev_code || digit_err !== prev_err) begin
        if (q_upd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_update actual=%h/%h expected=none", digit_code, digit_err);
        end else begin
          upd_t u;
          u = q_upd.pop_front();
          chk("update_code", 32'(digit_code), 32'(u.code));
          chk("update_err", 32'(digit_err), 32'(u.err));
        end
        prev_code = digit_code;
        prev_err  = digit_err;
      end
      if (frame_valid === 1'b1) begin
        if (q_frm.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame actual=cycle %0d expected=none", cyc);
        end else begin
          frm_t f;
          f = q_frm.pop_front();
          chk("frame_cycle", 32'(cyc), 32'(f.cyc));
          chk("frame_code", 32'(digit_code), 32'(f.code));
        end
      end
      if (sel_err === 1'b1) begin
        if (q_sel.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_sel_err actual=cycle %0d expected=none", cyc);
        end else begin
          chk("sel_err_cycle", 32'(cyc), 32'(q_sel.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    seg_sel = 4'b0101;
    seg_led = 8'h5b;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seg_sel = 4'h0;
    seg_led = 8'h00;
    chk("reset_code", 32'(digit_code), 32'h0000FFFF);
    chk("reset_err", 32'(digit_err), 32'h0);
    chk("reset_frame", 32'(frame_valid), 32'h0);
    chk("reset_sel_err", 32'(sel_err), 32'h0);
    prev_code = digit_code;
    prev_err  = digit_err;
    armed = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Clean scan
    step(4'b0001, 8'h3f, 6);
    step(4'b0010, 8'h06, 6);
    step(4'b0100, 8'h5b, 6);
    step(4'b1000, 8'h4f, 6);
    chk("scan_code", 32'(digit_code), 32'h3210);

    // Glitch rejection: 8 must never appear
    step(4'b0001, 8'h7f, 3);
    step(4'b0001, 8'h6d, 6);
    chk("glitch_code", 32'(digit_code), 32'h3215);

    // Illegal pattern then blank on position 1
    step(4'b0010, 8'h80, 6);
    chk("illegal_err", 32'(digit_err), 32'h2);
    step(4'b0010, 8'h00, 6);
    chk("blank_code", 32'(digit_code), 32'h32F5);
    chk("blank_err", 32'(digit_err), 32'h0);

    // Select faults
    step(4'b0000, 8'h3f, 10);
    step(4'b0011, 8'h06, 5);
    step(4'b0000, 8'h00, 3);
    chk("selfault_code", 32'(digit_code), 32'h32F5);

    // Reset mid-frame discards partial captures
    step(4'b0001, 8'h3f, 6);
    step(4'b0010, 8'h06, 6);
    step(4'b0100, 8'h5b, 6);
    do_rst(1);
    step(4'b1000, 8'h66, 6);
    step(4'b0000, 8'h00, 4);
    step(4'b0001, 8'h7d, 6);
    step(4'b0010, 8'h07, 6);
    step(4'b0100, 8'h7f, 6);
    step(4'b0000, 8'h00, 4);
    chk("final_code", 32'(digit_code), 32'h4876);

    chk("upd_queue_empty", 32'(q_upd.size()), 32'h0);
    chk("frame_queue_empty", 32'(q_frm.size()), 32'h0);
    chk("sel_queue_empty", 32'(q_sel.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
